irq_conditioner: RTL and testbench

- Conditions raw board push-button / switch interrupt requests before they reach the top-level interrupt latches feeding MIPS_CPU.
- Per channel it:
  - synchronises the raw input to the fast board clock;
  - debounces it;
  - detects the debounced rising edge;
  - emits a clean fixed-width pulse on the matching inter*_in input.
- One-deep pending storage per channel: a press that arrives during an active pulse is not lost.
- Maskable; counts accepted events for display or debug.

---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_debounce_ch.sv | 41 ++++
 rtl/irq_conditioner.sv | 112 +++++++++++
 tb/tb_irq_conditioner.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and pulse-FSM encoding for the interrupt conditioner.
package irq_pkg;

    localparam int IRQ_N_CH            = 3;
    localparam int IRQ_DEBOUNCE_CYCLES = 100000;
    localparam int IRQ_PULSE_CYCLES    = 16;
    localparam int IRQ_CNT_W           = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/irq_debounce_ch.sv
// Single-channel 2-flop synchroniser plus debounce counter; db_level follows sync2 after
// DEBOUNCE_CYCLES stable cycles (raw edge k -> db_level after edge k+1+DEBOUNCE_CYCLES); no backpressure.
module irq_debounce_ch
    import irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = IRQ_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_raw,
    output logic db_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            db_level <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            // Any sample matching the current level restarts the stability count.
            if (sync2 == db_level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/irq_conditioner.sv
// Per-channel debounce, rising-edge accept, fixed-width irq pulse with one-deep pending and event counter.
// Latency: raw edge k -> irq_out after edge k+2+DEBOUNCE_CYCLES; no backpressure, a third overlapping event is dropped.
module irq_conditioner
    import irq_pkg::*;
#(
    parameter int N_CH            = IRQ_N_CH,
    parameter int DEBOUNCE_CYCLES = IRQ_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = IRQ_PULSE_CYCLES,
    parameter int CNT_W           = IRQ_CNT_W
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [N_CH-1:0]         btn_raw,
    input  logic [N_CH-1:0]         irq_mask,
    output logic [N_CH-1:0]         irq_out,
    output logic [N_CH-1:0]         db_level,
    output logic [N_CH-1:0]         irq_pending,
    output logic [N_CH*CNT_W-1:0]   evt_count
);

    // Counter also holds PULSE_CYCLES so a re-entered pulse can spend one cycle low.
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_state_t     state, state_nxt;
        logic [PW-1:0]    pcnt, pcnt_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             db_prev;
        logic             out_q, out_nxt;
        logic             pend_q, pend_nxt;
        logic             accept;
        logic             pend_eff;

        irq_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .clr      (clr),
            .btn_raw  (btn_raw[i]),
            .db_level (db_level[i])
        );

        assign accept   = db_level[i] & ~db_prev & irq_mask[i];
        assign pend_eff = pend_q & irq_mask[i];

        always_comb begin
            state_nxt = state;
            pcnt_nxt  = pcnt;
            cnt_nxt   = cnt;
            out_nxt   = out_q;
            pend_nxt  = pend_eff;
            case (state)
                IDLE: begin
                    out_nxt  = 1'b0;
                    pend_nxt = 1'b0;
                    if (accept) begin
                        state_nxt = PULSE;
                        pcnt_nxt  = PW'(PULSE_CYCLES - 1);
                        out_nxt   = 1'b1;
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (pcnt == '0) begin
                        out_nxt  = 1'b0;
                        pend_nxt = 1'b0;
                        // Fresh pulse starts low for one cycle so the downstream latch sees a new edge.
                        if (pend_eff || accept) begin
                            pcnt_nxt = PW'(PULSE_CYCLES);
                            if (!pend_eff) begin
                                cnt_nxt = cnt + CNT_W'(1);
                            end
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        pcnt_nxt = pcnt - PW'(1);
                        out_nxt  = 1'b1;
                        if (accept && !pend_eff) begin
                            pend_nxt = 1'b1;
                            cnt_nxt  = cnt + CNT_W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                state   <= IDLE;
                pcnt    <= '0;
                cnt     <= '0;
                db_prev <= 1'b0;
                out_q   <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                state   <= state_nxt;
                pcnt    <= pcnt_nxt;
                cnt     <= cnt_nxt;
                db_prev <= db_level[i];
                out_q   <= out_nxt;
                pend_q  <= pend_nxt;
            end
        end

        assign irq_out[i]                  = out_q;
        assign irq_pending[i]              = pend_q;
        assign evt_count[i*CNT_W +: CNT_W] = cnt;
    end

endmodule

// File: tb/tb_irq_conditioner.sv
// Randomised and directed checks of irq_conditioner against a time-window reference model;
// a second instance with a long pulse makes the pending path reachable.
module tb_irq_conditioner;

    localparam int N_CH  = 3;
    localparam int DEB   = 4;
    localparam int CNT_W = 4;
    localparam int P_A   = 3;
    localparam int P_B   = 24;
    localparam int FAR   = -1000000;

    logic                  clk = 1'b0;
    logic                  clr;
    logic [N_CH-1:0]       btn_raw;
    logic [N_CH-1:0]       irq_mask;
    logic [N_CH-1:0]       irq_out_w   [2];
    logic [N_CH-1:0]       db_level_w  [2];
    logic [N_CH-1:0]       irq_pend_w  [2];
    logic [N_CH*CNT_W-1:0] evt_w       [2];

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;

    // Reference model state, per instance and channel
    int m_s1   [2][N_CH];
    int m_s2   [2][N_CH];
    int m_db   [2][N_CH];
    int m_run  [2][N_CH];
    int m_rose [2][N_CH];
    int m_pend [2][N_CH];
    int m_cnt  [2][N_CH];
    int m_from [2][N_CH];
    int m_to   [2][N_CH];
    int m_end  [2][N_CH];

    always #5 clk = ~clk;

    irq_conditioner #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(P_A), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .clr(clr), .btn_raw(btn_raw), .irq_mask(irq_mask),
        .irq_out(irq_out_w[0]), .db_level(db_level_w[0]),
        .irq_pending(irq_pend_w[0]), .evt_count(evt_w[0])
    );

    irq_conditioner #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(P_B), .CNT_W(CNT_W)
    ) u_dut_long (
        .clk(clk), .clr(clr), .btn_raw(btn_raw), .irq_mask(irq_mask),
        .irq_out(irq_out_w[1]), .db_level(db_level_w[1]),
        .irq_pending(irq_pend_w[1]), .evt_count(evt_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, t);
        end
    endtask

    function automatic int plen(input int d);
        return (d == 0) ? P_A : P_B;
    endfunction

    task automatic model_reset(input int d, input int c);
        m_s1[d][c] = 0; m_s2[d][c] = 0; m_db[d][c] = 0; m_run[d][c] = 0;
        m_rose[d][c] = 0; m_pend[d][c] = 0; m_cnt[d][c] = 0;
        m_from[d][c] = FAR; m_to[d][c] = FAR; m_end[d][c] = FAR;
    endtask

    // Pulses are tracked as windows of edge numbers: high after edges m_from..m_to, finished at m_end.
    task automatic model_edge(input int d, input int c);
        int acc, pe, p;
        p   = plen(d);
        acc = m_rose[d][c] & int'(irq_mask[c]);
        pe  = m_pend[d][c] & int'(irq_mask[c]);
        if (t == m_end[d][c]) begin
            if (pe != 0 || acc != 0) begin
                if (pe == 0) m_cnt[d][c] = (m_cnt[d][c] + 1) % (1 << CNT_W);
                m_from[d][c] = t + 1;
                m_to[d][c]   = t + p;
                m_end[d][c]  = t + p + 1;
            end
            m_pend[d][c] = 0;
        end else if (t < m_end[d][c]) begin
            if (acc != 0 && pe == 0) begin
                m_pend[d][c] = 1;
                m_cnt[d][c]  = (m_cnt[d][c] + 1) % (1 << CNT_W);
            end else begin
                m_pend[d][c] = pe;
            end
        end else begin
            m_pend[d][c] = 0;
            if (acc != 0) begin
                m_cnt[d][c]  = (m_cnt[d][c] + 1) % (1 << CNT_W);
                m_from[d][c] = t;
                m_to[d][c]   = t + p - 1;
                m_end[d][c]  = t + p;
            end
        end
        m_rose[d][c] = 0;
        if (m_s2[d][c] != m_db[d][c]) begin
            m_run[d][c]++;
            if (m_run[d][c] == DEB) begin
                m_db[d][c]   = m_s2[d][c];
                m_run[d][c]  = 0;
                m_rose[d][c] = m_db[d][c];
            end
        end else begin
            m_run[d][c] = 0;
        end
        m_s2[d][c] = m_s1[d][c];
        m_s1[d][c] = int'(btn_raw[c]);
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic [N_CH-1:0]       eo, ep, ed;
            logic [N_CH*CNT_W-1:0] ec;
            string s;
            s  = (d == 0) ? "a" : "b";
            eo = '0; ep = '0; ed = '0; ec = '0;
            for (int c = 0; c < N_CH; c++) begin
                eo[c] = (t >= m_from[d][c] && t <= m_to[d][c]);
                ep[c] = (m_pend[d][c] != 0);
                ed[c] = (m_db[d][c] != 0);
                ec[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[d][c]);
            end
            check({"irq_out_", s},     32'(irq_out_w[d]),  32'(eo));
            check({"irq_pending_", s}, 32'(irq_pend_w[d]), 32'(ep));
            check({"db_level_", s},    32'(db_level_w[d]), 32'(ed));
            check({"evt_count_", s},   32'(evt_w[d]),      32'(ec));
        end
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N_CH; c++)
                if (clr) model_reset(d, c);
                else     model_edge(d, c);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    function automatic int cnt_of(input int d, input int c);
        return int'(evt_w[d][c*CNT_W +: CNT_W]);
    endfunction

    initial begin
        int s_edge, rise_at, n_rise, c0, pend_seen, seen7, misalign, r0, r1, g0, hi, lo, seen;
        bit q[$];
        int runs[$];
        int gaps[$];

        clr = 1'b1; btn_raw = '0; irq_mask = 3'b111;
        for (int d = 0; d < 2; d++) for (int c = 0; c < N_CH; c++) model_reset(d, c);
        run(2);
        check("reset_irq_out", 32'(irq_out_w[0]), 32'd0);
        check("reset_pending", 32'(irq_pend_w[0]), 32'd0);
        check("reset_db", 32'(db_level_w[0]), 32'd0);
        check("reset_evt", 32'(evt_w[0]), 32'd0);
        clr = 1'b0;
        run(2);

        // Clean press on ch0: raw sampled first at edge k = t+1
        btn_raw[0] = 1'b1;
        run(5);
        check("clean_db_early", 32'(db_level_w[0][0]), 32'd0);
        step();
        check("clean_db", 32'(db_level_w[0][0]), 32'd1);
        check("clean_no_irq_yet", 32'(irq_out_w[0][0]), 32'd0);
        for (int j = 0; j < 3; j++) begin
            step();
            check("clean_pulse_hi", 32'(irq_out_w[0][0]), 32'd1);
        end
        step();
        check("clean_pulse_end", 32'(irq_out_w[0][0]), 32'd0);
        check("clean_evt", 32'(cnt_of(0, 0)), 32'd1);
        run(4);

        // Bounce on ch1
        btn_raw[1] = 1'b1; step();
        btn_raw[1] = 1'b0; step();
        btn_raw[1] = 1'b1; step();
        btn_raw[1] = 1'b0; step();
        btn_raw[1] = 1'b1;
        s_edge = t + 1; rise_at = -1; n_rise = 0;
        for (int j = 0; j < 20; j++) begin
            logic prev;
            prev = irq_out_w[0][1];
            step();
            if (irq_out_w[0][1] && !prev) begin
                n_rise++;
                if (rise_at < 0) rise_at = t;
            end
        end
        check("bounce_rise_edge", 32'(rise_at), 32'(s_edge + DEB + 2));
        check("bounce_one_pulse", 32'(n_rise), 32'd1);
        check("bounce_evt", 32'(cnt_of(0, 1)), 32'd1);

        // Back-to-back on the long-pulse instance, ch0
        btn_raw[0] = 1'b0;
        run(30);
        c0 = cnt_of(1, 0); pend_seen = 0;
        btn_raw[0] = 1'b1; run(7);
        q.push_back(irq_out_w[1][0]);
        btn_raw[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin step(); q.push_back(irq_out_w[1][0]); end
        btn_raw[0] = 1'b1;
        for (int j = 0; j < 6; j++) begin step(); q.push_back(irq_out_w[1][0]); pend_seen |= int'(irq_pend_w[1][0]); end
        btn_raw[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin step(); q.push_back(irq_out_w[1][0]); pend_seen |= int'(irq_pend_w[1][0]); end
        btn_raw[0] = 1'b1;
        for (int j = 0; j < 40; j++) begin step(); q.push_back(irq_out_w[1][0]); pend_seen |= int'(irq_pend_w[1][0]); end
        hi = 0; lo = 0; seen = 0;
        foreach (q[j]) begin
            if (q[j]) begin
                if (seen != 0 && hi == 0) gaps.push_back(lo);
                hi++; lo = 0;
            end else begin
                if (hi > 0) begin runs.push_back(hi); seen = 1; end
                hi = 0; lo++;
            end
        end
        if (hi > 0) runs.push_back(hi);
        r0 = (runs.size() > 0) ? runs[0] : -1;
        r1 = (runs.size() > 1) ? runs[1] : -1;
        g0 = (gaps.size() > 0) ? gaps[0] : -1;
        check("b2b_pending_seen", 32'(pend_seen), 32'd1);
        check("b2b_num_pulses", 32'(runs.size()), 32'd2);
        check("b2b_pulse1_len", 32'(r0), 32'(P_B));
        check("b2b_gap_len", 32'(g0), 32'd1);
        check("b2b_pulse2_len", 32'(r1), 32'(P_B));
        check("b2b_evt_drop", 32'(cnt_of(1, 0)), 32'((c0 + 2) % (1 << CNT_W)));

        // Masked channel debounces but stays silent
        btn_raw[1] = 1'b0; run(10);
        irq_mask = 3'b101;
        c0 = cnt_of(0, 1); seen = 0;
        btn_raw[1] = 1'b1;
        for (int j = 0; j < 12; j++) begin step(); seen |= int'(irq_out_w[0][1]); end
        check("mask_db", 32'(db_level_w[0][1]), 32'd1);
        check("mask_no_irq", 32'(seen), 32'd0);
        check("mask_evt", 32'(cnt_of(0, 1)), 32'(c0));
        irq_mask = 3'b111;
        btn_raw[1] = 1'b0; run(10);

        // Asynchronous reset in the second cycle of a pulse
        btn_raw[0] = 1'b0; run(30);
        btn_raw[0] = 1'b1; run(8);
        check("rst_pulse_live", 32'(irq_out_w[0][0]), 32'd1);
        #3 clr = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_irq_out", 32'(irq_out_w[d]), 32'd0);
            check("rst_pending", 32'(irq_pend_w[d]), 32'd0);
            check("rst_db", 32'(db_level_w[d]), 32'd0);
            check("rst_evt", 32'(evt_w[d]), 32'd0);
        end
        run(2);
        clr = 1'b0;

        // Counter wrap on ch2
        for (int j = 1; j <= 16; j++) begin
            btn_raw[2] = 1'b1; run(7);
            btn_raw[2] = 1'b0; run(6);
            if (j == 15) check("wrap_at_15", 32'(cnt_of(0, 2)), 32'd15);
        end
        check("wrap_to_0", 32'(cnt_of(0, 2)), 32'd0);

        // Simultaneous press on all channels
        btn_raw = '0; run(12);
        btn_raw = 3'b111; seen7 = 0; misalign = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (irq_out_w[0] == 3'b111) seen7++;
            else if (irq_out_w[0] != 3'b000) misalign++;
        end
        check("simul_aligned", 32'(misalign), 32'd0);
        check("simul_cycles", 32'(seen7), 32'(P_A));

        // Random stimulus against the model
        for (int j = 0; j < 1500; j++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(7) == 0) btn_raw[c] = ~btn_raw[c];
            if ($urandom_range(63) == 0) irq_mask = N_CH'($urandom_range(7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
